// File: rtl/apb_requester.sv
// APB3 requester: one valid/ready command in, one single APB transfer out,
// one response pulse back, with a PREADY wait-state timeout.
module apb_requester #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WLAST = CW'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              pen_q, pen_d;
  logic              pwrite_q, pwrite_d;
  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d;
  logic              rvld_q, rvld_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;
  logic [CW-1:0]     wait_q, wait_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rvld_q   <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rvld_q   <= rvld_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rvld_d   = 1'b0;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    wait_d   = wait_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_write ? cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        pen_d   = 1'b1;
        wait_d  = '0;
      end
      ACCESS: begin
        // PREADY wins over a timeout landing on the same edge
        if (PREADY) begin
          state_d = IDLE;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rvld_d  = 1'b1;
          rdata_d = pwrite_q ? '0 : PRDATA;
          rerr_d  = PSLVERR;
        end else if (TO_EN && wait_q == WLAST) begin
          state_d = IDLE;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rvld_d  = 1'b1;
          rdata_d = '0;
          rerr_d  = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign PSEL      = psel_q;
  assign PENABLE   = pen_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rvld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: command table, behavioural APB completer,
// and a response scoreboard with latency tracking.
module tb_apb_requester;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            nw;
    logic [DW-1:0] prd;
    logic          se;
    int            gap;
    bit            b2b;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rd;
    logic          er;
    int            lat;
    int            hs;
  } exp_t;

  logic          clk = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  apb_requester #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(clk), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int prev_hs = 0;
  exp_t sb[$];
  vec_t tbl[$];

  logic          cur_w = 1'b0;
  logic [AW-1:0] cur_a = '0;
  logic [DW-1:0] cur_wd = '0;
  int            cur_nw = 0;
  logic [DW-1:0] cur_prd = '0;
  logic          cur_se = 1'b0;
  int            acc_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    else
      n_pass++;
  endtask

  // Completer model: drives PREADY for the next edge and checks APB stability
  always @(negedge clk) begin
    if (PSEL && PENABLE) begin
      if (acc_cnt >= cur_nw) begin
        PREADY  = 1'b1;
        PRDATA  = cur_prd;
        PSLVERR = cur_se;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom);
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      PREADY  = 1'($urandom);
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom);
    end
    if (PRESETn && PSEL) begin
      chk("paddr", 64'(PADDR), 64'(cur_a));
      chk("pwrite", 64'(PWRITE), 64'(cur_w));
      chk("pwdata", 64'(PWDATA), cur_w ? 64'(cur_wd) : 64'd0);
    end
  end

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (PRESETn && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
        chk("rsp_err", 64'(rsp_err), 64'(e.er));
        chk("rsp_latency", 64'(cyc - e.hs), 64'(e.lat));
        chk("ready_at_rsp", 64'(cmd_ready), 64'd1);
      end
    end
  end

  task automatic drive(vec_t v);
    exp_t e;
    bit   to;
    int   hs;
    int   guard;
    repeat (v.gap) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
      cmd_write = 1'($urandom);
    end
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = v.w;
    cmd_addr  = v.a;
    cmd_wdata = v.wd;
    guard = 0;
    while (!cmd_ready) begin
      if (guard > 100) begin
        chk("ready_timeout", 64'd0, 64'd1);
        return;
      end
      guard++;
      @(negedge clk);
    end
    hs = cyc;
    if (v.b2b) chk("b2b_spacing", 64'(hs - prev_hs), 64'd3);
    prev_hs = hs;
    cur_w = v.w; cur_a = v.a; cur_wd = v.wd;
    cur_nw = v.nw; cur_prd = v.prd; cur_se = v.se;
    to = (v.nw >= TO);
    e.rd  = (to || v.w) ? '0 : v.prd;
    e.er  = to ? 1'b1 : v.se;
    e.lat = to ? 2 + TO : 3 + v.nw;
    e.hs  = hs;
    sb.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    int guard;
    PRESETn   = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'hF;
    cmd_wdata = 32'hFFFF_FFFF;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;

    //            w     a      wd            nw   prd           se    gap b2b
    tbl.push_back('{1'b1, 4'h3, 32'hA5A5_0001, 0,  32'hDEAD_BEEF, 1'b0, 1, 1'b0});
    tbl.push_back('{1'b0, 4'h5, 32'h1111_1111, 3,  32'h0000_00C3, 1'b0, 2, 1'b0});
    tbl.push_back('{1'b0, 4'h7, 32'h0,         0,  32'h1234_5678, 1'b1, 1, 1'b0});
    tbl.push_back('{1'b1, 4'h9, 32'h0BAD_CAFE, 0,  32'h5555_5555, 1'b0, 0, 1'b1});
    tbl.push_back('{1'b0, 4'h2, 32'h0,         100,32'h7777_7777, 1'b0, 2, 1'b0});
    tbl.push_back('{1'b0, 4'h4, 32'h0,         15, 32'h0BAD_F00D, 1'b1, 1, 1'b0});
    tbl.push_back('{1'b1, 4'h6, 32'hCAFE_0006, 16, 32'h6666_6666, 1'b0, 1, 1'b0});
    tbl.push_back('{1'b1, 4'h1, 32'h0000_0011, 0,  32'h0,         1'b0, 1, 1'b0});
    tbl.push_back('{1'b0, 4'h8, 32'h0,         0,  32'h8888_0008, 1'b0, 0, 1'b1});
    tbl.push_back('{1'b1, 4'hF, 32'hF0F0_F0F0, 0,  32'h0,         1'b0, 0, 1'b1});
    tbl.push_back('{1'b0, 4'hA, 32'h0,         0,  32'hAAAA_000A, 1'b0, 0, 1'b1});
    tbl.push_back('{1'b1, 4'hB, 32'h0000_B00B, 2,  32'h0,         1'b1, 2, 1'b0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_pwrite", 64'(PWRITE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b0;
    PRESETn   = 1'b1;

    foreach (tbl[i]) drive(tbl[i]);
    @(negedge clk);
    cmd_valid = 1'b0;

    guard = 0;
    while (sb.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_table", 64'(sb.size()), 64'd0);

    // Reset while a read sits in ACCESS waiting for PREADY
    drive('{1'b0, 4'hE, 32'h0, 5, 32'h1234_0000, 1'b0, 1, 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!(PSEL && PENABLE) && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("reached_access", 64'(PSEL && PENABLE), 64'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_psel", 64'(PSEL), 64'd0);
    chk("async_penable", 64'(PENABLE), 64'd0);
    chk("async_ready", 64'(cmd_ready), 64'd1);
    sb.delete();
    cmd_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("no_accept_in_rst", 64'(PSEL), 64'd0);
    cmd_valid = 1'b0;
    PRESETn   = 1'b1;

    drive('{1'b0, 4'hC, 32'h0, 1, 32'h0000_55AA, 1'b0, 3, 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_after_rst", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("idle_rdata_hold", 64'(rsp_rdata), 64'h55AA);
    chk("idle_paddr_hold", 64'(PADDR), 64'hC);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
# apb_requester

APB requester (bus master) that turns a simple valid/ready command stream into single APB3 transfers and returns one response per command. It drives the PSEL/PENABLE/PADDR/PWRITE/PWDATA side of the APB bus and consumes PRDATA/PREADY/PSLVERR from a completer, such as the SPI master register block. One transfer is in flight at a time, and the block adds a wait-state timeout so a hung completer cannot stall the requester.

## Interface

- AWIDTH, default 4: address width.
- DWIDTH, default 32: data width.
- TIMEOUT, default 16: maximum ACCESS cycles spent waiting for PREADY. 0 disables the timeout.

- PCLK  in  1  bus clock; all logic is on the rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AWIDTH  transfer address.
- cmd_wdata  in  DWIDTH  write data; ignored for reads.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DWIDTH  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR or timeout occurred.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  AWIDTH  APB address.
- PWDATA  out  DWIDTH  APB write data; 0 during reads.
- PRDATA  in  DWIDTH  completer read data.
- PREADY  in  1  completer ready; a completer may tie it to 1.
- PSLVERR  in  1  completer error; sampled only when PREADY=1 in ACCESS.

## Operation

- The FSM has three states: IDLE, SETUP and ACCESS. The reset state is IDLE.
- cmd_ready is 1 exactly when state = IDLE. The handshake fires when cmd_valid and cmd_ready are both 1 at a PCLK edge.
- IDLE → SETUP on a handshake. At the same edge:
  - cmd_write, cmd_addr and cmd_wdata are latched into PWRITE, PADDR and PWDATA.
  - PWDATA is forced to 0 when cmd_write = 0.
- SETUP: PSEL=1 and PENABLE=0 for exactly one cycle, then SETUP → ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1. A wait counter starts at 0 on entry and increments on each ACCESS edge with PREADY=0.
  - PREADY=1 → IDLE. Capture rsp_rdata = PRDATA for a read or 0 for a write, and rsp_err = PSLVERR. Set rsp_valid=1 for the next cycle.
  - Timeout: PREADY=0 with TIMEOUT≠0 and counter = TIMEOUT-1 → IDLE. Set rsp_err=1, rsp_rdata=0 and rsp_valid=1. PSEL and PENABLE drop.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle. They hold their last values in IDLE.
- All APB outputs and all rsp_* outputs are registered.
- rsp_rdata and rsp_err hold their values until the next response.
- There is no response back-pressure: rsp_valid is a pulse and the consumer must take it.

## Timing

- Reset values, applied asynchronously on PRESETn low: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0.
- While PRESETn is low, cmd_ready reads 1 (state is IDLE), but no command is accepted.
- Cycle numbering with PREADY=1:
  - Handshake at edge 0.
  - Cycle 1 (SETUP): PSEL=1.
  - Cycle 2 (ACCESS): PENABLE=1.
  - Cycle 3: rsp_valid=1 and cmd_ready=1.
- Command-to-response latency is 3 cycles plus N wait states.
- Peak throughput is one transfer per 3 cycles. A new handshake may occur in the same cycle that rsp_valid=1.
- Timeout latency is 2 + TIMEOUT cycles from handshake to rsp_valid.
- PREADY=1 in the same cycle the timeout would fire: the transfer completes normally, the response is not a timeout, and rsp_err = PSLVERR.
- PRDATA and PSLVERR are ignored outside ACCESS with PREADY=1.
- Reset mid-transfer (SETUP or ACCESS): PSEL and PENABLE drop immediately, no rsp_valid is issued, and the command is lost.
- cmd_* inputs may change freely when no handshake occurs.

## Test plan

- Write addr=0x3 data=0xA5A5_0001, PREADY tied to 1 → PSEL high in cycles 1-2, PENABLE high in cycle 2 with PWRITE=1 and PWDATA=0xA5A5_0001; rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read addr=0x5, PREADY low for 3 ACCESS cycles, then high with PRDATA=0x0000_00C3 → ACCESS lasts 4 cycles; rsp_valid at cycle 6 with rsp_rdata=0xC3 and PWDATA=0 throughout.
- Read with PREADY=1 and PSLVERR=1 → rsp_err=1 and rsp_rdata=PRDATA; the next command is accepted in the rsp_valid cycle.
- TIMEOUT=16, PREADY held 0 → exactly 16 ACCESS cycles, then PSEL=0 and rsp_valid=1 with rsp_err=1 and rsp_rdata=0 at cycle 18.
- Four back-to-back commands with cmd_valid held high, PREADY=1 → handshakes at cycles 0, 3, 6 and 9; PADDR changes only at SETUP entry; four responses in order.
- PRESETn pulsed low during ACCESS → PSEL and PENABLE go 0 asynchronously and no rsp_valid is issued; after release the block accepts a new command and completes it normally.
